// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - iterative RV32M multiply/divide unit with register-file writeback
module muldiv_iter #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd,
    output logic            busy,
    output logic            done,
    output logic            wb_we,
    output logic [4:0]      wb_wa,
    output logic [XLEN-1:0] wb_wd
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  SMIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [2:0]          f3_q;
    logic [4:0]          rd_q;
    logic [XLEN-1:0]     b_q;
    logic [2*XLEN-1:0]   acc_q;
    logic                neg_q_q, neg_r_q;

    logic                is_div, sgn1, sgn2, neg1, neg2;
    logic                div_zero, div_ovf, fast;
    logic [XLEN-1:0]     mag1, mag2, fast_res;

    logic [XLEN-1:0]     addend;
    logic [XLEN:0]       mul_sum, rem_sh, rem_diff;
    logic [2*XLEN-1:0]   acc_nxt, prod;
    logic [XLEN-1:0]     quo_fix, rem_fix, calc_res;

    // Operand preparation on the raw inputs, only consumed when an op is accepted.
    always_comb begin
        is_div   = funct3[2];
        sgn1     = is_div ? ~funct3[0] : (funct3 != 3'b011);
        sgn2     = is_div ? ~funct3[0] : ~funct3[1];
        neg1     = sgn1 & rs1_val[XLEN-1];
        neg2     = sgn2 & rs2_val[XLEN-1];
        mag1     = neg1 ? -rs1_val : rs1_val;
        mag2     = neg2 ? -rs2_val : rs2_val;
        div_zero = is_div && (rs2_val == '0);
        div_ovf  = is_div && !funct3[0] && (rs1_val == SMIN) && (rs2_val == '1);
        fast     = div_zero | div_ovf;
        fast_res = '0;
        if (div_zero) begin
            fast_res = funct3[1] ? rs1_val : '1;
        end else if (!funct3[1]) begin
            fast_res = SMIN;
        end
    end

    // One iteration: multiply keeps {partial product, remaining multiplier bits};
    // divide keeps {partial remainder, dividend bits shifting into quotient}.
    always_comb begin
        addend   = acc_q[0] ? b_q : '0;
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, addend};
        rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        rem_diff = rem_sh - {1'b0, b_q};
        if (f3_q[2]) begin
            if (!rem_diff[XLEN]) begin
                acc_nxt = {rem_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            end else begin
                acc_nxt = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_nxt = {mul_sum, acc_q[XLEN-1:1]};
        end
        prod    = neg_q_q ? -acc_nxt : acc_nxt;
        quo_fix = neg_q_q ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
        rem_fix = neg_r_q ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
        case (f3_q)
            3'b000:                 calc_res = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: calc_res = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         calc_res = quo_fix;
            default:                calc_res = rem_fix;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = fast ? S_DONE : S_CALC;
            S_CALC: if (cnt_q == LAST) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign busy = (state_q != S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            f3_q    <= '0;
            rd_q    <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            done    <= 1'b0;
            wb_we   <= 1'b0;
            wb_wa   <= '0;
            wb_wd   <= '0;
        end else begin
            done  <= (state_d == S_DONE);
            wb_we <= 1'b0;
            if (!flush) begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            f3_q    <= funct3;
                            rd_q    <= rd;
                            neg_q_q <= neg1 ^ neg2;
                            neg_r_q <= neg1;
                            cnt_q   <= '0;
                            b_q     <= is_div ? mag2 : mag1;
                            acc_q   <= {{XLEN{1'b0}}, (is_div ? mag1 : mag2)};
                            if (fast) begin
                                wb_we <= (rd != 5'd0);
                                wb_wa <= rd;
                                wb_wd <= fast_res;
                            end
                        end
                    end
                    S_CALC: begin
                        acc_q <= acc_nxt;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST) begin
                            cnt_q <= '0;
                            wb_we <= (rd_q != 5'd0);
                            wb_wa <= rd_q;
                            wb_wd <= calc_res;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
